iob_mem_arb_sp: RTL

- N-port IOb-native memory front-end. Arbitrates N requesters (CPU I/D buses, DMA, debug) onto one internal single-port byte-enable RAM (iob_ram_sp_be).
- Generalises the fixed two-port instruction/data SRAM hookup to a parametrised channel count with fair arbitration, backpressure and per-port read-data return.
- Sits between SoC bus masters and on-chip SRAM in the memory wrapper.

---
 rtl/iob_mem_arb_pkg.sv | 16 +
 rtl/iob_mem_arb_if.sv | 20 ++
 rtl/iob_mem_arb_sp_arb.sv | 71 +++++++
 rtl/iob_ram_sp_be.sv | 29 ++
 rtl/iob_mem_arb_sp.sv | 71 +++++++
 5 files changed

// File: rtl/iob_mem_arb_pkg.sv
// Shared helpers for the N-port memory arbiter: pointer width and bus slicing/decode macros.
`ifndef IOB_MEM_ARB_PKG_SV
`define IOB_MEM_ARB_PKG_SV

// Port k of a flattened per-port bus of element width w
`define IOB_MEM_ARB_SLICE(k, w) ((k)*(w)) +: (w)
// Any set strobe makes the access a write
`define IOB_MEM_ARB_IS_WR(s) (|(s))

package iob_mem_arb_pkg;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

`endif

// File: rtl/iob_mem_arb_if.sv
// Flattened IOb-native request/response bus for all requester ports.
interface iob_mem_arb_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32
);
  logic [N_PORTS-1:0]          valid_i;
  logic [N_PORTS*ADDR_W-1:0]   addr_i;
  logic [N_PORTS*DATA_W-1:0]   wdata_i;
  logic [N_PORTS*DATA_W/8-1:0] wstrb_i;
  logic [N_PORTS-1:0]          lock_i;
  logic [N_PORTS-1:0]          ready_o;
  logic [N_PORTS-1:0]          rvalid_o;
  logic [N_PORTS*DATA_W-1:0]   rdata_o;

  modport master (output valid_i, addr_i, wdata_i, wstrb_i, lock_i,
                  input  ready_o, rvalid_o, rdata_o);
  modport slave  (input  valid_i, addr_i, wdata_i, wstrb_i, lock_i,
                  output ready_o, rvalid_o, rdata_o);
endinterface

// File: rtl/iob_mem_arb_sp_arb.sv
// Round-robin arbiter with rotating pointer; optional grant lock under IOB_MEM_ARB_LOCK_EN.
module iob_rr_arbiter
  import iob_mem_arb_pkg::*;
#(
  parameter  int N     = 2,
  localparam int PTR_W = ptr_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cke,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     lock,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  logic [PTR_W-1:0] ptr, sel;
  logic             found, locked;

  always_comb begin
    int p;
    found = 1'b0;
    sel   = '0;
    p     = 0;
    for (int i = 0; i < N; i++) begin
      p = (int'(ptr) + i) % N;
      if (!found && req[p]) begin
        found = 1'b1;
        sel   = PTR_W'(p);
      end
    end
  end

`ifdef IOB_MEM_ARB_LOCK_EN
  logic [PTR_W-1:0] last_idx;
  logic             last_vld;

  assign locked = last_vld && lock[last_idx] && req[last_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_idx <= '0;
      last_vld <= 1'b0;
    end else if (gnt_vld) begin
      last_idx <= gnt_idx;
      last_vld <= 1'b1;
    end
  end

  assign gnt_idx = locked ? last_idx : sel;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign locked      = 1'b0;
  assign gnt_idx     = sel;
`endif

  assign gnt_vld = (found || locked) && cke && !rst;

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  // A held lock freezes the pointer so round-robin resumes after the locked port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (gnt_vld && !locked)
      ptr <= (gnt_idx == PTR_W'(N-1)) ? '0 : gnt_idx + PTR_W'(1);
  end
endmodule

// File: rtl/iob_ram_sp_be.sv
// Single-port byte-enable RAM with registered read output (updated on reads only).
module iob_ram_sp_be #(
  parameter     HEXFILE = "none",
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   d_i,
  output logic [DATA_W-1:0]   d_o
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Preload images are attached to this scope by the implementation flow
  if (HEXFILE != "none") begin : g_hex
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < STRB_W; b++)
        if (we_i[b]) mem[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
      if (~|we_i) d_o <= mem[addr_i];
    end
  end
endmodule

// File: rtl/iob_mem_arb_sp.sv
// N-port IOb memory front-end: round-robin arbitration onto one single-port BE RAM.
// Grant locking is compiled in with IOB_MEM_ARB_LOCK_EN (see iob_rr_arbiter).
module iob_mem_arb_sp
  import iob_mem_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter     HEXFILE = "none"
) (
  input logic          clk_i,
  input logic          arst_i,
  input logic          cke_i,
  iob_mem_arb_if.slave bus
);
  localparam int PTR_W  = ptr_w(N_PORTS);
  localparam int STRB_W = DATA_W / 8;

  logic [N_PORTS-1:0]             gnt, rvalid;
  logic [PTR_W-1:0]               gnt_idx, rd_owner;
  logic                           gnt_vld, rd_pend;
  logic [ADDR_W-1:0]              ram_addr;
  logic [DATA_W-1:0]              ram_wdata, ram_rdata;
  logic [STRB_W-1:0]              ram_wstrb;
  logic [N_PORTS-1:0][DATA_W-1:0] rdata_q;

  iob_rr_arbiter #(.N(N_PORTS)) u_arb (
    .clk     (clk_i),
    .rst     (arst_i),
    .cke     (cke_i),
    .req     (bus.valid_i),
    .lock    (bus.lock_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign bus.ready_o = gnt;
  assign ram_addr    = bus.addr_i[`IOB_MEM_ARB_SLICE(gnt_idx, ADDR_W)];
  assign ram_wdata   = bus.wdata_i[`IOB_MEM_ARB_SLICE(gnt_idx, DATA_W)];
  assign ram_wstrb   = bus.wstrb_i[`IOB_MEM_ARB_SLICE(gnt_idx, STRB_W)];

  iob_ram_sp_be #(.HEXFILE(HEXFILE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk_i  (clk_i),
    .en_i   (gnt_vld),
    .we_i   (ram_wstrb),
    .addr_i (ram_addr),
    .d_i    (ram_wdata),
    .d_o    (ram_rdata)
  );

  // The RAM output is shown directly during the rvalid cycle and captured into
  // the owner's hold register at the next enabled edge.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_pend  <= 1'b0;
      rd_owner <= '0;
      rdata_q  <= '0;
    end else if (cke_i) begin
      if (rd_pend) rdata_q[rd_owner] <= ram_rdata;
      rd_pend <= gnt_vld && !`IOB_MEM_ARB_IS_WR(ram_wstrb);
      if (gnt_vld) rd_owner <= gnt_idx;
    end
  end

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    assign rvalid[k] = rd_pend && (rd_owner == PTR_W'(k));
    assign bus.rdata_o[k*DATA_W +: DATA_W] = rvalid[k] ? ram_rdata : rdata_q[k];
  end
  assign bus.rvalid_o = rvalid;
endmodule
